// File: rtl/iterative_shift_ctrl.sv
// Multi-cycle SLL/SRL/SRA unit: a 1-bit shift stage is applied once per clock,
// shamt times, under a start/busy/done handshake.
module iterative_shift_ctrl #(
  parameter int Width  = 32,
  parameter int ShamtW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [Width-1:0]  operand,
  input  logic [ShamtW-1:0] shamt,
  output logic              busy,
  output logic              done,
  output logic [Width-1:0]  result,
  output logic              err,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a request is accepted on any rising edge where start=1 and the
  // unit is not busy (IDLE or DONE). done is a one-cycle pulse marking result
  // valid; a new request may be accepted in that same done cycle.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t            r_state;
  logic [Width-1:0]  r_data;
  logic [ShamtW-1:0] r_count;
  logic [1:0]        r_op;
  logic              r_err;
  logic              w_accept;

  assign w_accept = start && (r_state != S_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_count <= '0;
      r_op    <= OP_SLL;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_data  <= operand;
            r_count <= shamt;
            r_op    <= op;
            r_err   <= (op == OP_RSV);
            // Reserved op and zero shift skip straight to the result cycle.
            if ((shamt == '0) || (op == OP_RSV)) r_state <= S_DONE;
            else                                  r_state <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          case (r_op)
            OP_SLL:  r_data <= {r_data[Width-2:0], 1'b0};
            OP_SRL:  r_data <= {1'b0, r_data[Width-1:1]};
            OP_SRA:  r_data <= {r_data[Width-1], r_data[Width-1:1]};
            default: r_data <= r_data;
          endcase
          // count is always >= 1 in SHIFT, so the decrement never wraps.
          r_count <= r_count - 1'b1;
          if (r_count == ShamtW'(1)) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == S_SHIFT);
  assign done        = (r_state == S_DONE);
  assign err         = r_err && (r_state == S_DONE);
  assign result      = r_data;
  assign o_dbg_state = r_state;

endmodule

// File: doc/iterative_shift_ctrl.md
Name: iterative_shift_ctrl

Overview:
- Multi-cycle shift unit for the RISC-V datapath, for area-reduced builds where a full barrel shifter is not wanted.
- A controller FSM sequences a single 1-bit shift stage: one bit position per clock, repeated shamt times.
- Supports SLL, SRL and SRA, with a start/busy/done handshake towards the core's execute-stage stall logic.

Parameters:
- Width, 32, data width in bits.
- ShamtW, 5, shift-amount width; must equal log2(Width).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
- operand  input  Width  value to shift; captured on accept.
- shamt  input  ShamtW  shift amount; captured on accept.
- busy  output  1  high while in SHIFT state.
- done  output  1  one-cycle pulse; result valid from this cycle.
- result  output  Width  shifted value; held until next accept or reset.
- err  output  1  high together with done when op=11 was accepted.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, busy=0, done=0, err=0, result=0, internal count=0, internal data=0.
  - Reset has priority over every other input.
  - Reset during SHIFT aborts the operation; no done is produced.
- States: IDLE, SHIFT, DONE (2-bit encoding). busy = (state==SHIFT). done = (state==DONE).
- Accept condition: start=1 while state is IDLE or DONE. A new request may be accepted in the same cycle done is high (back-to-back).
- On accept edge:
  - data<=operand, count<=shamt, op latched, err flag latched = (op==11).
  - Next state is DONE if shamt==0 or op==11; otherwise SHIFT.
- SHIFT, each edge:
  - data shifted one position. SLL: data<={data[Width-2:0],0}. SRL: data<={0,data[Width-1:1]}. SRA: data<={data[Width-1],data[Width-1:1]}.
  - count<=count-1.
  - If count==1 before the edge, next state is DONE; otherwise stay in SHIFT.
- result mirrors the internal data register. It may change while busy=1; consumers sample result only when done=1.
- Latency: start sampled in cycle k → done in cycle k+1+shamt (shamt=0 → k+1). Fixed latency; no early exit on zero data.
- op=11: no shift; result=operand, err=1 during the single done cycle. err is 0 in all other cycles.
- start while busy=1 is ignored; operand, shamt and op changes during SHIFT have no effect.
- DONE with no start → IDLE next edge. done is never high for two consecutive cycles unless a new request (shamt=0 or op=11) is accepted in the done cycle.
- shamt=Width-1 (31): 31 shift cycles. The count field never wraps, because the decrement only occurs while count≥1.
- Arithmetic is unsigned on count. No sign extension beyond the SRA rule above.

Test Plan:
- Reset: assert rst for 2 cycles mid-SHIFT (SLL, shamt=20, 5 cycles in) → busy=0, done=0, result=0 next cycle, no done pulse afterwards.
- SLL operand=0x0000_0001, shamt=4, start in cycle k → busy high in cycles k+1..k+4; done=1 in cycle k+5 with result=0x0000_0010, err=0.
- SRA operand=0x8000_0000, shamt=31 → done in cycle k+32 with result=0xFFFF_FFFF. Then SRL with the same operand/shamt → result=0x0000_0001.
- shamt=0 SRL operand=0xDEAD_BEEF → done in cycle k+1, result=0xDEAD_BEEF. Then op=11 operand=0x1234_5678 → done and err=1 one cycle after accept, result=0x1234_5678.
- Back-to-back: start held high in the done cycle of SLL 0x1,shamt=1 with new SRL 0xF0,shamt=4 → first result=0x2; second done exactly 5 cycles later with result=0x0F.
- Ignore-while-busy: start pulse with op=SLL, operand=0xFFFF_FFFF, shamt=3, issued during an SRL shamt=8 of 0x100 → only one done, result=0x1, at k+9.
